// File: rtl/mioc_flop_seq.sv
// Request/ready sequencer that programs a bank of N mioc open-drain flops with
// ordered reset/set/clock pulses and a q readback check after every operation.
module mioc_flop_lane #(
  parameter int IDX = 0,
  parameter int AW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic          d_val,
  input  logic          pulse_on,
  input  logic          pulse_off,
  input  logic [1:0]    op,
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic          line_rst,
  output logic          line_clk,
  output logic          line_d,
  output logic          line_set
);
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic d_hit;

  assign hit   = (addr == AW'(IDX));
  assign d_hit = (d_addr == AW'(IDX));

  // D is written at accept so it is stable a full cycle before the clock rises
  always_ff @(posedge clk) begin
    if (reset) begin
      line_rst <= 1'b0;
      line_clk <= 1'b0;
      line_d   <= 1'b0;
      line_set <= 1'b0;
    end else begin
      if (d_we && d_hit)
        line_d <= d_val;
      if (pulse_on) begin
        line_rst <= (op == OP_CLEAR) || ((op == OP_RESET) && hit);
        line_set <= (op == OP_SET) && hit;
        line_clk <= (op == OP_WRITE) && hit;
      end else if (pulse_off) begin
        line_rst <= 1'b0;
        line_set <= 1'b0;
        line_clk <= 1'b0;
      end
    end
  end
endmodule

module mioc_flop_seq #(
  parameter int N      = 6,
  parameter int AW     = 3,
  parameter int PW     = 2,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [1:0]    op,
  input  logic [AW-1:0] addr,
  input  logic          wdata,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [N-1:0]  flop_rst,
  output logic [N-1:0]  flop_clk,
  output logic [N-1:0]  flop_d,
  output logic [N-1:0]  flop_set,
  input  logic [N-1:0]  flop_q
);
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam int CMAX = (PW > SETTLE) ? PW : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ASSERT, S_SETTLE, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic [AW-1:0]   addr_q;
  logic            wdata_q;
  logic            accept, bad_addr, pulse_on, pulse_off, d_we;
  logic            q_sel, chk_err;
  logic [N-1:0]    addr_hit;

  assign ready     = (state == S_IDLE) && !reset;
  assign busy      = (state != S_IDLE);
  assign accept    = req && ready;
  assign bad_addr  = (op != OP_CLEAR) && ({1'b0, addr} >= (AW+1)'(N));
  assign d_we      = accept && (op == OP_WRITE) && !bad_addr;
  assign pulse_on  = (state == S_SETUP);
  assign pulse_off = (state == S_ASSERT) && (state_n == S_SETTLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (accept) state_n = bad_addr ? S_DONE : S_SETUP;
      S_SETUP:  state_n = S_ASSERT;
      S_ASSERT: if (cnt == '0) state_n = S_SETTLE;
      S_SETTLE: if (cnt == '0) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Dwell counter reloads on every state change so ASSERT/SETTLE last PW/SETTLE cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_n != state) begin
      if (state_n == S_ASSERT)      cnt <= CW'(PW - 1);
      else if (state_n == S_SETTLE) cnt <= CW'(SETTLE - 1);
      else                          cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_WRITE;
      addr_q  <= '0;
      wdata_q <= 1'b0;
    end else if (accept) begin
      op_q    <= op;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mioc_flop_lane #(.IDX(i), .AW(AW)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .d_we      (d_we),
      .d_addr    (addr),
      .d_val     (wdata),
      .pulse_on  (pulse_on),
      .pulse_off (pulse_off),
      .op        (op_q),
      .addr      (addr_q),
      .hit       (addr_hit[i]),
      .line_rst  (flop_rst[i]),
      .line_clk  (flop_clk[i]),
      .line_d    (flop_d[i]),
      .line_set  (flop_set[i])
    );
  end

  assign q_sel = |(flop_q & addr_hit);

  always_comb begin
    chk_err = 1'b0;
    case (op_q)
      OP_WRITE: chk_err = (q_sel != wdata_q);
      OP_SET:   chk_err = !q_sel;
      OP_RESET: chk_err = q_sel;
      OP_CLEAR: chk_err = |flop_q;
      default:  chk_err = 1'b1;
    endcase
  end

  // Readback is taken on the edge leaving SETTLE; a direct IDLE->DONE is a bad address
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= (state_n == S_DONE);
      err  <= (state_n == S_DONE) && ((state == S_IDLE) ? 1'b1 : chk_err);
    end
  end
endmodule

// File: tb/tb_mioc_flop_seq.sv
// Directed bench for mioc_flop_seq with a behavioral open-drain flop bank model.
module tb_mioc_flop_seq;
  localparam int N  = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, req, wdata;
  logic [1:0]    op;
  logic [AW-1:0] addr;
  logic          ready, busy, done, err;
  logic [N-1:0]  flop_rst, flop_clk, flop_d, flop_set, flop_q, mq, stuck;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mioc_flop_seq #(.N(N), .AW(AW), .PW(2), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready), .busy(busy), .done(done), .err(err),
    .flop_rst(flop_rst), .flop_clk(flop_clk), .flop_d(flop_d),
    .flop_set(flop_set), .flop_q(flop_q)
  );

  // async reset/set flop capturing D on the falling clock edge
  for (genvar g = 0; g < N; g++) begin : g_model
    logic b = 1'b0;
    always @(negedge flop_clk[g] or posedge flop_rst[g] or posedge flop_set[g]) begin
      if (flop_rst[g])      b <= 1'b0;
      else if (flop_set[g]) b <= 1'b1;
      else                  b <= flop_d[g];
    end
    assign mq[g] = b;
  end
  assign flop_q = mq & ~stuck;

  typedef struct {
    logic [1:0] op;
    logic [2:0] addr;
    logic       wd;
    logic [5:0] stuck;
    int         lat;
    logic       er;
    logic [5:0] q;
    logic [5:0] d;
    int         nr, ns, nc;
    logic [5:0] touch;
    int         first;
    int         dchg;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mk(logic [1:0] o, logic [2:0] a, logic w, logic [5:0] s,
                              int l, logic e, logic [5:0] q, logic [5:0] d,
                              int nr, int ns, int nc, logic [5:0] t, int f, int dc);
    vec_t v;
    v.op = o; v.addr = a; v.wd = w; v.stuck = s; v.lat = l; v.er = e; v.q = q; v.d = d;
    v.nr = nr; v.ns = ns; v.nc = nc; v.touch = t; v.first = f; v.dchg = dc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, nr, ns, nc, first, dchg;
    logic er, inv;
    logic [N-1:0] touch, qv, dprev, clkprev;
    logic [12:1] bz, dn;
    logic seen_done;

    //           op     ad  wd stuck     lat er  q          d          nr ns nc touch      first dchg
    tv[0]  = mk(2'b00, 2, 1, 6'b000000, 5, 0, 6'b000100, 6'b000100, 0, 0, 2, 6'b000100,  2,  1);
    tv[1]  = mk(2'b01, 5, 0, 6'b000000, 5, 0, 6'b100100, 6'b000100, 0, 2, 0, 6'b100000,  2, -1);
    tv[2]  = mk(2'b10, 5, 0, 6'b000000, 5, 0, 6'b000100, 6'b000100, 2, 0, 0, 6'b100000,  2, -1);
    tv[3]  = mk(2'b00, 0, 1, 6'b000000, 5, 0, 6'b000101, 6'b000101, 0, 0, 2, 6'b000001,  2,  1);
    tv[4]  = mk(2'b00, 1, 1, 6'b000000, 5, 0, 6'b000111, 6'b000111, 0, 0, 2, 6'b000010,  2,  1);
    tv[5]  = mk(2'b00, 3, 1, 6'b000000, 5, 0, 6'b001111, 6'b001111, 0, 0, 2, 6'b001000,  2,  1);
    tv[6]  = mk(2'b00, 4, 1, 6'b000000, 5, 0, 6'b011111, 6'b011111, 0, 0, 2, 6'b010000,  2,  1);
    tv[7]  = mk(2'b00, 5, 1, 6'b000000, 5, 0, 6'b111111, 6'b111111, 0, 0, 2, 6'b100000,  2,  1);
    tv[8]  = mk(2'b11, 0, 0, 6'b000000, 5, 0, 6'b000000, 6'b111111, 2, 0, 0, 6'b111111,  2, -1);
    tv[9]  = mk(2'b00, 6, 1, 6'b000000, 1, 1, 6'b000000, 6'b111111, 0, 0, 0, 6'b000000, -1, -1);
    tv[10] = mk(2'b01, 7, 0, 6'b000000, 1, 1, 6'b000000, 6'b111111, 0, 0, 0, 6'b000000, -1, -1);
    tv[11] = mk(2'b00, 1, 0, 6'b000010, 5, 0, 6'b000000, 6'b111101, 0, 0, 2, 6'b000010,  2,  1);
    tv[12] = mk(2'b00, 1, 1, 6'b000010, 5, 1, 6'b000000, 6'b111111, 0, 0, 2, 6'b000010,  2,  1);
    tv[13] = mk(2'b00, 2, 1, 6'b000000, 5, 0, 6'b000110, 6'b111111, 0, 0, 2, 6'b000100,  2, -1);

    reset = 1'b1; req = 1'b0; op = 2'b00; addr = '0; wdata = 1'b0; stuck = '0;
    repeat (3) step();
    chk("rst.ready", ready, 0);
    chk("rst.lines", flop_rst | flop_clk | flop_d | flop_set, 0);
    chk("rst.done_err", {done, err}, 0);
    reset = 1'b0;
    #1;
    chk("rel.ready_busy", {ready, busy}, 2'b10);

    for (int i = 0; i < 14; i++) begin
      stuck = tv[i].stuck; op = tv[i].op; addr = tv[i].addr; wdata = tv[i].wd; req = 1'b1;
      lat = -1; er = 1'bx; qv = 'x; nr = 0; ns = 0; nc = 0; first = -1; dchg = -1;
      touch = '0; inv = 1'b0; dprev = flop_d; clkprev = '0;
      for (int c = 1; c <= 20; c++) begin
        step();
        req = 1'b0;
        if (|flop_rst) nr++;
        if (|flop_set) ns++;
        if (|flop_clk) nc++;
        touch |= flop_rst | flop_set | flop_clk;
        if (first < 0 && |(flop_rst | flop_set | flop_clk)) first = c;
        if (dchg < 0 && flop_d !== dprev) dchg = c;
        for (int j = 0; j < N; j++)
          if (int'(flop_rst[j]) + int'(flop_set[j]) + int'(flop_clk[j]) > 1) inv = 1'b1;
        if ((|flop_clk || |clkprev) && flop_d !== dprev) inv = 1'b1;
        if (!busy || ready || (!done && err)) inv = 1'b1;
        dprev = flop_d; clkprev = flop_clk;
        if (done) begin
          lat = c; er = err; qv = flop_q;
          break;
        end
      end
      chk($sformatf("v%0d.lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d.err", i), er, tv[i].er);
      chk($sformatf("v%0d.q", i), qv, tv[i].q);
      chk($sformatf("v%0d.d", i), flop_d, tv[i].d);
      chk($sformatf("v%0d.nrst", i), nr, tv[i].nr);
      chk($sformatf("v%0d.nset", i), ns, tv[i].ns);
      chk($sformatf("v%0d.nclk", i), nc, tv[i].nc);
      chk($sformatf("v%0d.touch", i), touch, tv[i].touch);
      chk($sformatf("v%0d.first", i), first, tv[i].first);
      chk($sformatf("v%0d.dchg", i), dchg, tv[i].dchg);
      chk($sformatf("v%0d.invariant", i), inv, 0);
      step();
      chk($sformatf("v%0d.idle", i), {ready, busy, done, err}, 4'b1000);
    end
    stuck = '0;

    // reset during the set pulse
    op = 2'b01; addr = 3'd3; req = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("midrst.set_on", flop_set, 6'b001000);
    reset = 1'b1;
    step();
    chk("midrst.lines", flop_rst | flop_clk | flop_d | flop_set, 0);
    chk("midrst.done_ready", {done, ready}, 0);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    chk("midrst.no_done", seen_done, 0);
    chk("midrst.ready", ready, 1);

    // req held high across a whole op
    op = 2'b00; addr = 3'd0; wdata = 1'b1; req = 1'b1;
    bz = '0; dn = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      bz[c] = busy;
      dn[c] = done;
    end
    req = 1'b0;
    chk("held.busy", bz, 12'b011111011111);
    chk("held.done", dn, 12'b010000010000);
    step();
    chk("held.idle", {ready, busy}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
